mem_bus_arbiter: RTL and testbench

//  Shares the single-port 256x16 RAM and the memory-mapped I/O (LED register, switch port)

---
 rtl/mem_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares a single-port 256x16 RAM, a write-only LED register and a read-only
// switch port between two bus masters (r0 = cpu, r1 = loader/debug master).
// Owns address decode, arbitration, write steering and the one-cycle read
// return path.
// Optional feature macro: ARB_RR_EN
//   defined   -> round-robin arbitration on simultaneous requests
//   undefined -> fixed priority r0 > r1 with a starvation breaker for r1

module mem_bus_arbiter #(
   parameter int         STARVE_MAX = 4,
   parameter logic [8:0] LED_ADDR   = 9'h100,
   parameter logic [8:0] SW_ADDR    = 9'h140
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  r0_cmd,
   input  logic [8:0]  r0_addr,
   input  logic [15:0] r0_wdata,
   output logic        r0_gnt,
   output logic        r0_rvalid,
   output logic [15:0] r0_rdata,
   input  logic [1:0]  r1_cmd,
   input  logic [8:0]  r1_addr,
   input  logic [15:0] r1_wdata,
   output logic        r1_gnt,
   output logic        r1_rvalid,
   output logic [15:0] r1_rdata,
   output logic [7:0]  ram_addr,
   output logic        ram_write,
   output logic [15:0] ram_din,
   input  logic [15:0] ram_dout,
   input  logic [7:0]  sw,
   output logic [8:0]  led
);

   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_READ  = 2'b10;

   // Per-cycle arbitration outcome; the registered copy doubles as the
   // "who owns the pending read" tag for the next cycle.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arbState_t;

   // Where the data for a pending read comes from.
   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_SW   = 2'd2
   } readSrc_t;

   arbState_t   state_d, state_q;
   logic        pendValid_d, pendValid_q;
   readSrc_t    pendSrc_d, pendSrc_q;
   logic [8:0]  led_d, led_q;
   logic [7:0]  swCap_q;

   logic        r0Req, r1Req;
   logic        conflictToR1;
   logic [1:0]  winCmd;
   logic [8:0]  winAddr;
   logic [15:0] winWdata;
   logic        winWrite, winRead;
   logic [15:0] readMux;

`ifdef ARB_RR_EN
   arbState_t   lastWin_d, lastWin_q;
`else
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] starveCnt_d, starveCnt_q;
`endif

   // Only write and read are real requests; 00 and 11 are ignored
   always_comb begin
      r0Req = (r0_cmd == CMD_WRITE) || (r0_cmd == CMD_READ);
      r1Req = (r1_cmd == CMD_WRITE) || (r1_cmd == CMD_READ);
   end

`ifdef ARB_RR_EN
   // On a conflict, the master that did not win last time goes first
   always_comb begin
      conflictToR1 = (lastWin_q == GRANT0);
   end
`else
   // On a conflict r0 wins unless r1 has been starved long enough
   always_comb begin
      conflictToR1 = (starveCnt_q == CNT_W'(STARVE_MAX));
   end
`endif

   // Pick this cycle's winner; nobody is granted while reset is held
   always_comb begin
      state_d = IDLE;
      if (!reset) begin
         if (r0Req && r1Req) begin
            state_d = conflictToR1 ? GRANT1 : GRANT0;
         end else if (r0Req) begin
            state_d = GRANT0;
         end else if (r1Req) begin
            state_d = GRANT1;
         end
      end
   end

   // Steer the winner onto the RAM/LED side and prepare the read tag
   always_comb begin
      winCmd      = 2'b00;
      winAddr     = 9'h000;
      winWdata    = 16'h0000;
      case (state_d)
         GRANT0: begin
            winCmd   = r0_cmd;
            winAddr  = r0_addr;
            winWdata = r0_wdata;
         end
         GRANT1: begin
            winCmd   = r1_cmd;
            winAddr  = r1_addr;
            winWdata = r1_wdata;
         end
         default: begin
         end
      endcase

      winWrite  = (winCmd == CMD_WRITE);
      winRead   = (winCmd == CMD_READ);

      r0_gnt    = (state_d == GRANT0);
      r1_gnt    = (state_d == GRANT1);
      ram_addr  = winAddr[7:0];
      ram_write = winWrite && !winAddr[8];
      ram_din   = winWdata;

      led_d = led_q;
      if (winWrite && (winAddr == LED_ADDR)) begin
         led_d = winWdata[8:0];
      end

      pendValid_d = winRead;
      if (!winAddr[8]) begin
         pendSrc_d = SRC_RAM;
      end else if (winAddr == SW_ADDR) begin
         pendSrc_d = SRC_SW;
      end else begin
         pendSrc_d = SRC_ZERO;
      end
   end

`ifdef ARB_RR_EN
   // Remember the most recent winner; idle cycles leave it alone
   always_comb begin
      lastWin_d = (state_d == IDLE) ? lastWin_q : state_d;
   end
`else
   // Count cycles r1 asks and loses; any r1 grant or idle r1 clears it
   always_comb begin
      starveCnt_d = '0;
      if (r1Req && (state_d != GRANT1)) begin
         starveCnt_d = starveCnt_q + CNT_W'(1);
      end
   end
`endif

   // State, read tag, LED register and switch snapshot
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         pendValid_q <= 1'b0;
         pendSrc_q   <= SRC_ZERO;
         led_q       <= 9'h000;
         swCap_q     <= 8'h00;
`ifdef ARB_RR_EN
         lastWin_q   <= GRANT1;
`else
         starveCnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pendValid_q <= pendValid_d;
         pendSrc_q   <= pendSrc_d;
         led_q       <= led_d;
         swCap_q     <= sw;
`ifdef ARB_RR_EN
         lastWin_q   <= lastWin_d;
`else
         starveCnt_q <= starveCnt_d;
`endif
      end
   end

   // Return read data one cycle after the grant, to the master that won it
   always_comb begin
      case (pendSrc_q)
         SRC_RAM: readMux = ram_dout;
         SRC_SW:  readMux = {8'h00, swCap_q};
         default: readMux = 16'h0000;
      endcase
      r0_rvalid = pendValid_q && (state_q == GRANT0) && !reset;
      r1_rvalid = pendValid_q && (state_q == GRANT1) && !reset;
      r0_rdata  = r0_rvalid ? readMux : 16'h0000;
      r1_rdata  = r1_rvalid ? readMux : 16'h0000;
      led       = led_q;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Drives both masters with directed and random traffic, emulates the RAM,
// and compares every cycle against a transaction-level model of the arbiter.
// Honours ARB_RR_EN the same way the design does.

module tb_mem_bus_arbiter;

   localparam int STARVE = 4;

   logic        clk;
   logic        reset;
   logic [1:0]  r0_cmd, r1_cmd;
   logic [8:0]  r0_addr, r1_addr;
   logic [15:0] r0_wdata, r1_wdata;
   logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
   logic [15:0] r0_rdata, r1_rdata;
   logic [7:0]  ram_addr;
   logic        ram_write;
   logic [15:0] ram_din;
   bit   [15:0] ramDout;
   logic [7:0]  sw;
   logic [8:0]  led;

   bit   [15:0] tbMem [256];
   bit   [15:0] refMem [256];

   int total = 0;
   int bad   = 0;

   // Reference model state
   int          lastGrant = 1;
   int          starve    = 0;
   bit          pv        = 0;
   int          pw        = 0;
   logic [15:0] pd        = 16'h0000;
   logic [8:0]  refLed    = 9'h000;

   mem_bus_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .r0_cmd    (r0_cmd),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_gnt    (r0_gnt),
      .r0_rvalid (r0_rvalid),
      .r0_rdata  (r0_rdata),
      .r1_cmd    (r1_cmd),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_gnt    (r1_gnt),
      .r1_rvalid (r1_rvalid),
      .r1_rdata  (r1_rdata),
      .ram_addr  (ram_addr),
      .ram_write (ram_write),
      .ram_din   (ram_din),
      .ram_dout  (ramDout),
      .sw        (sw),
      .led       (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM with registered read, read-before-write
   always @(posedge clk) begin
      if (ram_write) tbMem[ram_addr] <= ram_din;
      ramDout <= tbMem[ram_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic stepPos();
      @(posedge clk);
      #1;
   endtask

   task automatic stepNeg();
      @(negedge clk);
   endtask

   function automatic bit isReq(input logic [1:0] c);
      return (c == 2'b01) || (c == 2'b10);
   endfunction

   task automatic applyStimulus(output logic [1:0] c, output logic [8:0] a, output logic [15:0] d);
      c = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
         0, 1:    a = 9'($urandom_range(0, 15));
         2:       a = 9'h100;
         3:       a = 9'h140;
         default: a = {1'b1, 8'($urandom_range(0, 255))};
      endcase
      d = 16'($urandom);
   endtask

   // Compare process: checks the DUT every cycle against the model, then
   // advances the model across the coming clock edge
   initial begin : compare
      int          win;
      bit          q0, q1, expWr;
      logic [1:0]  wCmd;
      logic [8:0]  wAddr;
      logic [15:0] wData;
      logic [7:0]  expAddr;
      forever begin
         @(negedge clk);
         if (reset) begin
            checkOutput("rst_gnt0", 32'(r0_gnt), 32'(0));
            checkOutput("rst_gnt1", 32'(r1_gnt), 32'(0));
            checkOutput("rst_rvalid0", 32'(r0_rvalid), 32'(0));
            checkOutput("rst_rvalid1", 32'(r1_rvalid), 32'(0));
            checkOutput("rst_ram_write", 32'(ram_write), 32'(0));
            checkOutput("rst_led", 32'(led), 32'(refLed));
            pv        = 0;
            refLed    = 9'h000;
            starve    = 0;
            lastGrant = 1;
         end else begin
            q0  = isReq(r0_cmd);
            q1  = isReq(r1_cmd);
            win = -1;
            if (q0 && q1) begin
`ifdef ARB_RR_EN
               win = (lastGrant == 0) ? 1 : 0;
`else
               win = (starve == STARVE) ? 1 : 0;
`endif
            end else if (q0) win = 0;
            else if (q1) win = 1;

            wCmd  = (win == 0) ? r0_cmd   : (win == 1) ? r1_cmd   : 2'b00;
            wAddr = (win == 0) ? r0_addr  : (win == 1) ? r1_addr  : 9'h000;
            wData = (win == 0) ? r0_wdata : (win == 1) ? r1_wdata : 16'h0000;
            expWr   = (wCmd == 2'b01) && !wAddr[8];
            expAddr = wAddr[7:0];

            checkOutput("gnt0", 32'(r0_gnt), 32'(win == 0));
            checkOutput("gnt1", 32'(r1_gnt), 32'(win == 1));
            checkOutput("rvalid0", 32'(r0_rvalid), 32'(pv && pw == 0));
            checkOutput("rvalid1", 32'(r1_rvalid), 32'(pv && pw == 1));
            checkOutput("rdata0", 32'(r0_rdata), (pv && pw == 0) ? 32'(pd) : 32'(0));
            checkOutput("rdata1", 32'(r1_rdata), (pv && pw == 1) ? 32'(pd) : 32'(0));
            checkOutput("ram_write", 32'(ram_write), 32'(expWr));
            checkOutput("ram_addr", 32'(ram_addr), 32'(expAddr));
            if (expWr) checkOutput("ram_din", 32'(ram_din), 32'(wData));
            checkOutput("led", 32'(led), 32'(refLed));

            pv = 0;
            if (win >= 0) begin
               if (wCmd == 2'b10) begin
                  pv = 1;
                  pw = win;
                  if (!wAddr[8]) pd = refMem[wAddr[7:0]];
                  else if (wAddr == 9'h140) pd = {8'h00, sw};
                  else pd = 16'h0000;
               end else begin
                  if (!wAddr[8]) refMem[wAddr[7:0]] = wData;
                  else if (wAddr == 9'h100) refLed = wData[8:0];
               end
               lastGrant = win;
            end
            starve = (q1 && win != 1) ? starve + 1 : 0;
         end
      end
   end

   // Directed scenarios with hand-computed expectations, then random traffic
   initial begin : stimulus
      bit          g0, g1;
      logic [1:0]  c;
      logic [8:0]  a;
      logic [15:0] d;
      bit          exp1;
      reset    = 1'b1;
      r0_cmd   = 2'b00; r0_addr = 9'h000; r0_wdata = 16'h0000;
      r1_cmd   = 2'b00; r1_addr = 9'h000; r1_wdata = 16'h0000;
      sw       = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // RAM write then read back
      r0_cmd = 2'b01; r0_addr = 9'h010; r0_wdata = 16'hABCD;
      stepNeg();
      checkOutput("t1_wr_gnt0", 32'(r0_gnt), 32'(1));
      checkOutput("t1_wr_ram_write", 32'(ram_write), 32'(1));
      checkOutput("t1_wr_ram_addr", 32'(ram_addr), 32'h10);
      checkOutput("t1_wr_ram_din", 32'(ram_din), 32'hABCD);
      stepPos();
      r0_cmd = 2'b10;
      stepNeg();
      checkOutput("t1_rd_gnt0", 32'(r0_gnt), 32'(1));
      checkOutput("t1_rd_ram_write", 32'(ram_write), 32'(0));
      stepPos();
      r0_cmd = 2'b00;
      stepNeg();
      checkOutput("t1_rvalid0", 32'(r0_rvalid), 32'(1));
      checkOutput("t1_rdata0", 32'(r0_rdata), 32'hABCD);

      // LED write from r1
      stepPos();
      r1_cmd = 2'b01; r1_addr = 9'h100; r1_wdata = 16'h01A5;
      stepNeg();
      checkOutput("t2_gnt1", 32'(r1_gnt), 32'(1));
      checkOutput("t2_ram_write", 32'(ram_write), 32'(0));
      stepPos();
      r1_cmd = 2'b00;
      stepNeg();
      checkOutput("t2_led", 32'(led), 32'h1A5);

      // Switch read then null read, back to back
      stepPos();
      sw = 8'h3C; r0_cmd = 2'b10; r0_addr = 9'h140;
      stepNeg();
      checkOutput("t3_gnt0", 32'(r0_gnt), 32'(1));
      stepPos();
      sw = 8'hFF; r0_addr = 9'h180;
      stepNeg();
      checkOutput("t3_sw_rvalid", 32'(r0_rvalid), 32'(1));
      checkOutput("t3_sw_rdata", 32'(r0_rdata), 32'h003C);
      stepPos();
      r0_cmd = 2'b00;
      stepNeg();
      checkOutput("t3_null_rvalid", 32'(r0_rvalid), 32'(1));
      checkOutput("t3_null_rdata", 32'(r0_rdata), 32'h0000);

      // Reset right after a read grant kills the return
      stepPos();
      r0_cmd = 2'b10; r0_addr = 9'h010;
      stepNeg();
      checkOutput("t5_gnt0", 32'(r0_gnt), 32'(1));
      stepPos();
      reset = 1'b1; r0_addr = 9'h011;
      stepNeg();
      checkOutput("t5_rvalid0", 32'(r0_rvalid), 32'(0));
      checkOutput("t5_gnt0_rst", 32'(r0_gnt), 32'(0));
      stepPos();
      stepNeg();
      checkOutput("t5_led", 32'(led), 32'(0));
      checkOutput("t5_rvalid0_b", 32'(r0_rvalid), 32'(0));
      stepPos();
      reset = 1'b0;

      // Both masters read every cycle from a fresh reset
      r0_cmd = 2'b10; r0_addr = 9'h010;
      r1_cmd = 2'b10; r1_addr = 9'h011;
      for (int i = 0; i < 10; i++) begin
         stepNeg();
`ifdef ARB_RR_EN
         exp1 = (i % 2) == 1;
`else
         exp1 = (i % 5) == 4;
`endif
         checkOutput("t4_gnt0", 32'(r0_gnt), 32'(!exp1));
         checkOutput("t4_gnt1", 32'(r1_gnt), 32'(exp1));
         stepPos();
      end
      r0_cmd = 2'b00; r1_cmd = 2'b00;
      reset  = 1'b1;
      stepPos();
      stepPos();
      reset  = 1'b0;

      // Conflicting write and read to the same RAM word
      r0_cmd = 2'b01; r0_addr = 9'h020; r0_wdata = 16'h1234;
      r1_cmd = 2'b10; r1_addr = 9'h020;
      stepNeg();
      checkOutput("t6_gnt0", 32'(r0_gnt), 32'(1));
      checkOutput("t6_gnt1_wait", 32'(r1_gnt), 32'(0));
      stepPos();
      r0_cmd = 2'b00;
      stepNeg();
      checkOutput("t6_gnt1", 32'(r1_gnt), 32'(1));
      stepPos();
      r1_cmd = 2'b00;
      stepNeg();
      checkOutput("t6_rvalid1", 32'(r1_rvalid), 32'(1));
      checkOutput("t6_rdata1", 32'(r1_rdata), 32'h1234);
      stepPos();

      // Random traffic: each master holds its request until granted
      for (int n = 0; n < 3000; n++) begin
         stepNeg();
         g0 = r0_gnt;
         g1 = r1_gnt;
         stepPos();
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 199) == 0) reset = 1'b1;
         if (g0 || !isReq(r0_cmd)) begin
            applyStimulus(c, a, d);
            r0_cmd = c; r0_addr = a; r0_wdata = d;
         end
         if (g1 || !isReq(r1_cmd)) begin
            applyStimulus(c, a, d);
            r1_cmd = c; r1_addr = a; r1_wdata = d;
         end
         sw = 8'($urandom);
      end

      stepNeg();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
